// File: rtl/fetch_stage_pkg.sv
// Shared constants, fetch FSM encodings and the IF/ID slot layout for the RV32I front end.
package fetch_stage_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] PC_STEP   = 32'd4;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    DISCARD = 2'd1,
    HOLD    = 2'd2,
    HALT    = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] pc;
    logic [31:0] pc4;
  } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// Pipeline slot register: flush beats load, otherwise holds. Flush clears valid and forces a NOP
// into ir while pc/pc4 keep their last values; contents appear one cycle after load.
module if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] NOP_IR = NOP_INSTR
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   load,
  input  logic   flush,
  input  if_id_t data,
  output logic   valid,
  output if_id_t q
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid <= 1'b0;
      q     <= '{ir: NOP_IR, pc: 32'd0, pc4: 32'd0};
    end else if (flush) begin
      valid <= 1'b0;
      q.ir  <= NOP_IR;
    end else if (load) begin
      valid <= 1'b1;
      q     <= data;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch + IF/ID register: ack to if_id_valid is one cycle; a stalled full slot parks
// one returned word in the hold buffer and stops requesting until the slot drains.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = fetch_stage_pkg::RESET_PC,
  parameter logic [31:0] NOP_INSTR = fetch_stage_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_id_valid,
  output logic [31:0] if_id_ir,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc4,
  output logic        misalign
);
  import fetch_stage_pkg::*;

  fetch_state_t state, state_nxt;
  logic [31:0]  pc, pc_nxt;
  logic [31:0]  hold_ir, hold_pc;
  logic         capture, load, flush, slot_free, misalign_nxt;
  if_id_t       load_data, slot;

  assign slot_free    = !if_id_valid || !stall;
  assign misalign_nxt = misalign || (redirect && (redirect_pc[1:0] != 2'b00));
  assign imem_req     = (state == FETCH);
  assign imem_addr    = pc;

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    capture   = 1'b0;
    load      = 1'b0;
    flush     = 1'b0;
    load_data = '{ir: imem_rdata, pc: pc, pc4: pc + PC_STEP};
    case (state)
      FETCH: begin
        if (imem_ack && slot_free) begin
          load   = 1'b1;
          pc_nxt = pc + PC_STEP;
        end else if (imem_ack) begin
          capture   = 1'b1;
          pc_nxt    = pc + PC_STEP;
          state_nxt = HOLD;
        end
      end
      DISCARD: if (imem_ack) state_nxt = FETCH;
      HOLD: begin
        if (!stall) begin
          load      = 1'b1;
          load_data = '{ir: hold_ir, pc: hold_pc, pc4: hold_pc + PC_STEP};
          state_nxt = FETCH;
        end
      end
      default: ;
    endcase
    // Redirect overrides everything: the in-flight word is dropped or its ack awaited in DISCARD.
    if (redirect) begin
      pc_nxt  = redirect_pc;
      flush   = 1'b1;
      load    = 1'b0;
      capture = 1'b0;
      if (state == FETCH) state_nxt = imem_ack ? FETCH : DISCARD;
      else if (state == HOLD) state_nxt = FETCH;
    end
    if (misalign_nxt && state_nxt == FETCH) state_nxt = HALT;
    if (!load && slot_free) flush = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      hold_ir  <= NOP_INSTR;
      hold_pc  <= 32'd0;
      misalign <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      misalign <= misalign_nxt;
      if (capture) begin
        hold_ir <= imem_rdata;
        hold_pc <= pc;
      end
    end
  end

  if_id_reg #(.NOP_IR(NOP_INSTR)) u_if_id (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .flush (flush),
    .data  (load_data),
    .valid (if_id_valid),
    .q     (slot)
  );

  assign if_id_ir  = slot.ir;
  assign if_id_pc  = slot.pc;
  assign if_id_pc4 = slot.pc4;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed table of per-cycle inputs and expected outputs, plus a zero-wait and wrap sequence.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, redirect, imem_req, imem_ack, if_id_valid, misalign;
  logic [31:0] redirect_pc, imem_addr, imem_rdata, if_id_ir, if_id_pc, if_id_pc4;
  logic        auto_mode, man_ack;
  logic [31:0] man_rdata;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0050_0093;
      32'h4:   return 32'h00A0_0113;
      32'h8:   return 32'h0000_0113;
      default: return {a[15:0], 16'h0013};
    endcase
  endfunction

  assign imem_ack   = auto_mode ? imem_req : man_ack;
  assign imem_rdata = auto_mode ? mem_word(imem_addr) : man_rdata;

  fetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .if_id_valid(if_id_valid), .if_id_ir(if_id_ir), .if_id_pc(if_id_pc), .if_id_pc4(if_id_pc4),
    .misalign(misalign)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        st, rd;
    logic [31:0] rpc;
    logic        ak;
    logic [31:0] rdt;
    logic        ereq;
    logic [31:0] eaddr;
    logic        ev;
    logic [31:0] eir, epc;
    logic        emis;
  } vec_t;

  function automatic vec_t mk(input logic st, rd, input logic [31:0] rpc, input logic ak,
                              input logic [31:0] rdt, input logic ereq, input logic [31:0] eaddr,
                              input logic ev, input logic [31:0] eir, epc, input logic emis);
    vec_t v;
    v = '{st: st, rd: rd, rpc: rpc, ak: ak, rdt: rdt, ereq: ereq, eaddr: eaddr,
          ev: ev, eir: eir, epc: epc, emis: emis};
    return v;
  endfunction

  vec_t tbl[22];

  initial begin
    // Expected columns describe outputs during the cycle in which the inputs are applied.
    tbl[0]  = mk(0, 0, 0,     0, 0,            1, 32'h0,   0, NOP,          0,     0);
    tbl[1]  = mk(0, 0, 0,     0, 0,            1, 32'h0,   0, NOP,          0,     0);
    tbl[2]  = mk(0, 0, 0,     1, 32'h00500093, 1, 32'h0,   0, NOP,          0,     0);
    tbl[3]  = mk(0, 0, 0,     1, 32'h00A00113, 1, 32'h4,   1, 32'h00500093, 0,     0);
    tbl[4]  = mk(1, 0, 0,     1, 32'h00000113, 1, 32'h8,   1, 32'h00A00113, 4,     0);
    tbl[5]  = mk(1, 0, 0,     0, 0,            0, 32'hC,   1, 32'h00A00113, 4,     0);
    tbl[6]  = mk(1, 0, 0,     0, 0,            0, 32'hC,   1, 32'h00A00113, 4,     0);
    tbl[7]  = mk(1, 0, 0,     0, 0,            0, 32'hC,   1, 32'h00A00113, 4,     0);
    tbl[8]  = mk(0, 0, 0,     0, 0,            0, 32'hC,   1, 32'h00A00113, 4,     0);
    tbl[9]  = mk(0, 0, 0,     0, 0,            1, 32'hC,   1, 32'h00000113, 8,     0);
    tbl[10] = mk(0, 1, 32'h20, 0, 0,           1, 32'hC,   0, NOP,          0,     0);
    tbl[11] = mk(0, 0, 0,     1, 32'hDEAD0013, 0, 32'h20,  0, NOP,          0,     0);
    tbl[12] = mk(0, 1, 32'h100, 0, 0,          1, 32'h20,  0, NOP,          0,     0);
    tbl[13] = mk(0, 0, 0,     0, 0,            0, 32'h100, 0, NOP,          0,     0);
    tbl[14] = mk(0, 0, 0,     1, 32'h20202013, 0, 32'h100, 0, NOP,          0,     0);
    tbl[15] = mk(0, 0, 0,     1, 32'h10000093, 1, 32'h100, 0, NOP,          0,     0);
    tbl[16] = mk(1, 1, 32'h200, 1, 32'hBAD00013, 1, 32'h104, 1, 32'h10000093, 32'h100, 0);
    tbl[17] = mk(0, 0, 0,     1, 32'h20000013, 1, 32'h200, 0, NOP,          0,     0);
    tbl[18] = mk(0, 1, 32'h102, 0, 0,          1, 32'h204, 1, 32'h20000013, 32'h200, 0);
    tbl[19] = mk(0, 0, 0,     1, 32'hDEAD0013, 0, 32'h102, 0, NOP,          0,     1);
    tbl[20] = mk(0, 0, 0,     0, 0,            0, 32'h102, 0, NOP,          0,     1);
    tbl[21] = mk(0, 0, 0,     1, 32'h12345013, 0, 32'h102, 0, NOP,          0,     1);

    rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    auto_mode = 1'b0; man_ack = 1'b0; man_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("reset_valid", {31'd0, if_id_valid}, 0);
    chk("reset_ir", if_id_ir, NOP);
    chk("reset_pc", if_id_pc, 0);
    chk("reset_pc4", if_id_pc4, 0);
    chk("reset_misalign", {31'd0, misalign}, 0);

    for (int i = 0; i < 22; i++) begin
      if (i > 0) @(negedge clk);
      stall = tbl[i].st; redirect = tbl[i].rd; redirect_pc = tbl[i].rpc;
      man_ack = tbl[i].ak; man_rdata = tbl[i].rdt;
      #1;
      chk($sformatf("row%0d_req", i), {31'd0, imem_req}, {31'd0, tbl[i].ereq});
      chk($sformatf("row%0d_addr", i), imem_addr, tbl[i].eaddr);
      chk($sformatf("row%0d_valid", i), {31'd0, if_id_valid}, {31'd0, tbl[i].ev});
      chk($sformatf("row%0d_ir", i), if_id_ir, tbl[i].eir);
      chk($sformatf("row%0d_misalign", i), {31'd0, misalign}, {31'd0, tbl[i].emis});
      if (tbl[i].ev) begin
        chk($sformatf("row%0d_pc", i), if_id_pc, tbl[i].epc);
        chk($sformatf("row%0d_pc4", i), if_id_pc4, tbl[i].epc + 32'd4);
      end
    end

    // Reset out of HALT, then zero-wait memory and PC wrap.
    @(negedge clk);
    rst = 1'b0; stall = 1'b0; redirect = 1'b0; man_ack = 1'b0;
    @(negedge clk);
    rst = 1'b1; auto_mode = 1'b1;
    #1;
    chk("rst2_misalign", {31'd0, misalign}, 0);
    chk("rst2_req", {31'd0, imem_req}, 1);
    chk("rst2_addr", imem_addr, 0);
    chk("rst2_valid", {31'd0, if_id_valid}, 0);
    @(negedge clk); #1;
    chk("zw1_valid", {31'd0, if_id_valid}, 1);
    chk("zw1_ir", if_id_ir, 32'h0050_0093);
    chk("zw1_pc", if_id_pc, 0);
    chk("zw1_pc4", if_id_pc4, 4);
    chk("zw1_addr", imem_addr, 4);
    @(negedge clk); #1;
    chk("zw2_ir", if_id_ir, 32'h00A0_0113);
    chk("zw2_pc", if_id_pc, 4);
    chk("zw2_pc4", if_id_pc4, 8);
    @(negedge clk);
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    #1;
    chk("zw3_ir", if_id_ir, 32'h0000_0113);
    chk("zw3_pc", if_id_pc, 8);
    @(negedge clk);
    redirect = 1'b0;
    #1;
    chk("wrap_flush_valid", {31'd0, if_id_valid}, 0);
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    @(negedge clk); #1;
    chk("wrap_valid", {31'd0, if_id_valid}, 1);
    chk("wrap_ir", if_id_ir, 32'hFFFC_0013);
    chk("wrap_pc", if_id_pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", if_id_pc4, 0);
    chk("wrap_next_addr", imem_addr, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage plus IF/ID pipeline register for the RV32I core.
- Owns the PC and issues word requests to instruction memory over a req/ack handshake.
- Registers the returned instruction word, PC and PC+4 for decode. if_id_ir is the IR input of the immediate generator and the decoder.
- Handles decode stall, redirect/flush from branch/jump resolution, and variable-latency memory through a one-entry hold buffer.

Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013: ADDI x0,x0,0, driven on if_id_ir whenever the slot is invalid.

Ports:
- clk  in  1  core clock, all state updates on its rising edge
- rst  in  1  synchronous, active-low reset
- stall  in  1  hazard unit: hold the IF/ID contents
- redirect  in  1  branch taken or JAL/JALR resolved: refetch from redirect_pc
- redirect_pc  in  32  target address
- imem_req  out  1  fetch request, held until acked
- imem_addr  out  32  word address, equal to the PC register
- imem_ack  in  1  imem_rdata valid this cycle; completes the request
- imem_rdata  in  32  fetched instruction
- if_id_valid  out  1  IF/ID slot holds a real instruction
- if_id_ir  out  32  instruction to decode and immediate generation
- if_id_pc  out  32  address of if_id_ir
- if_id_pc4  out  32  if_id_pc + 4, for JAL/JALR link
- misalign  out  1  sticky: redirect target not word aligned

Behaviour:
- Reset (rst==0 at the edge):
  - PC=RESET_PC; state=FETCH; hold buffer empty.
  - if_id_valid=0, if_id_ir=NOP_INSTR, if_id_pc=0, if_id_pc4=0, misalign=0.
  - Reset mid-transaction discards the outstanding request and needs no handshake completion.
- States:
  - FETCH: imem_req=1.
  - DISCARD: imem_req=0; waiting for the ack of a killed request.
  - HOLD: imem_req=0; hold buffer full.
  - HALT: imem_req=0.
- imem_addr=PC in all states. imem_req is 0 in every state except FETCH.
- Arithmetic: 32-bit modulo for PC+4, so 0xFFFF_FFFC wraps to 0.
- Slot free := !if_id_valid || !stall.
- FETCH with ack, no redirect:
  - Slot free: load IF/ID with {valid=1, ir=rdata, pc=PC, pc4=PC+4}; PC+=4; stay in FETCH. A zero-wait memory therefore gives 1 instruction/cycle.
  - Slot not free: capture {rdata, PC} in the hold buffer; PC+=4; go to HOLD.
- HOLD: when stall drops, move the buffer into IF/ID, empty the buffer, go to FETCH. No instruction is lost or duplicated.
- Stall with the slot valid: IF/ID contents are frozen bit-exact.
- Stall with the slot invalid: the slot still accepts data (bubble collapse).
- Redirect has the highest priority and overrides stall. Same cycle:
  - PC=redirect_pc; if_id_valid=0; if_id_ir=NOP_INSTR; hold buffer cleared.
  - FETCH with no ack this cycle: go to DISCARD.
  - FETCH with ack this cycle: drop rdata; stay in FETCH.
  - HOLD goes to FETCH.
- DISCARD: on ack, drop rdata and go to FETCH. A redirect during DISCARD only updates PC.
- Misaligned redirect (redirect_pc[1:0]!=0):
  - misalign=1 from the next cycle.
  - The slot is flushed and the state goes to HALT. If a request is outstanding, pass through DISCARD first.
  - HALT is left only by reset.
- Output timing: if_id_valid is only ever asserted one cycle after an ack (or the hold drain). The latency from ack to if_id_valid is exactly 1 cycle.

Decomposition:
- Shared package/defines: NOP_INSTR, RESET_PC, fetch state encodings (FETCH, DISCARD, HOLD, HALT), and a PC_STEP=4 constant.
- One natural sub-module: if_id_reg, the IF/ID register with load/flush/hold controls. It is reused by the later ID/EX register style.
- FSM and hold buffer stay in fetch_stage.

Test Plan:
- Zero-wait memory (ack tied to req, rdata=0x00500093 at 0, 0x00A00113 at 4) -> if_id_valid high from cycle 2; ir 0x00500093 pc 0 pc4 4, then 0x00A00113 pc 4, one per cycle.
- 3-cycle ack latency -> imem_req held high, imem_addr stable at 0 for 3 cycles; if_id_valid 1 cycle after the ack; new address 4 on the next cycle.
- stall=1 for 4 cycles while ack returns 0x00000113 at pc 8 -> IF/ID frozen at the pc-4 instruction, state HOLD, req=0. On release, ir=0x00000113 pc=8 appears, then fetch of 12 (0xC).
- redirect=1 to 0x100 while a request to 0x20 is outstanding (ack 2 cycles later) -> slot flushed to NOP/valid 0; the 0x20 data is dropped; next request addr 0x100; first valid pc=0x100.
- redirect and stall asserted together, with ack in the same cycle -> redirect wins: slot invalid, rdata dropped, next imem_addr=redirect_pc.
- redirect_pc=0x102 -> misalign=1 next cycle, imem_req stays 0; rst low one cycle -> misalign=0, fetch resumes at RESET_PC.
